phase_gen: RTL and testbench
============================

Name: phase_gen

Overview:
- Per-voice oscillator front end: converts a 7-bit MIDI note number into a phase increment and runs a phase accumulator at the sample rate.
- Drives the 7-bit PHASE input of the downstream wavetable/sample lookup stage; the top PHASE bit is the half-wave select used for mirroring there.
- Computes the increment with a small sequential divide-by-12 FSM and a 12-entry semitone table, so no 128-entry ROM is needed.

Parameters:
- ACC_WIDTH, 16, accumulator width in bits. The table values below assume 16 bits at fs = 48 kHz.
- PHASE_WIDTH, 7, number of accumulator MSBs presented on PHASE.
- RESET_ON_TRIG, 0, 1 = clear the accumulator on every NOTE_ON; 0 = phase-continuous retrigger.

Ports:
- CLK  in  1  system clock
- RST  in  1  synchronous reset, active-high
- CE  in  1  sample-rate enable, one-CLK pulse per sample
- NOTE  in  7  MIDI note number 0..127, sampled on NOTE_ON
- NOTE_ON  in  1  one-CLK strobe: start/retrigger the note
- NOTE_OFF  in  1  one-CLK strobe: stop the oscillator
- PHASE  out  PHASE_WIDTH  acc[ACC_WIDTH-1 -: PHASE_WIDTH]
- ACTIVE  out  1  an increment is loaded and the accumulator is advancing
- BUSY  out  1  increment computation in progress (DIV or LOAD state)
- WRAP  out  1  one-CLK pulse when the accumulator overflows on a CE

Behaviour:
- Reset (RST=1 at a CLK edge): acc=0, inc=0, state=IDLE, PHASE=0, ACTIVE=0, BUSY=0, WRAP=0. RST overrides every other input.
- Semitone table BASE[0..11] (decimal, normative): 11431, 12110, 12830, 13593, 14402, 15258, 16165, 17127, 18145, 19224, 20367, 21578.
- Increment rule: oct = NOTE/12 (range 0..10), s = NOTE mod 12, inc = BASE[s] >> (10 - oct). This is a logical shift with truncation.
- FSM states:
  - IDLE: waits for NOTE_ON.
  - DIV: entered the cycle after NOTE_ON, with rem=NOTE and oct=0. Each CLK: if rem >= 12, then rem -= 12 and oct += 1; else go to LOAD.
  - LOAD: one cycle; writes inc, sets ACTIVE=1, then goes to RUN.
  - RUN: holds until the next NOTE_ON or NOTE_OFF.
- DIV and LOAD advance on every CLK and are not gated by CE. BUSY=1 exactly while in DIV or LOAD.
- Latency: with NOTE_ON sampled at edge t, the new inc is in effect from edge t+oct+3. Example: note 69 has 6 DIV cycles plus 1 LOAD cycle, so BUSY is high for 7 cycles.
- Accumulation: on a CLK with CE=1 and ACTIVE=1, acc <= acc + inc, modulo 2^ACC_WIDTH.
  - WRAP=1 for that one cycle iff the addition carries out; otherwise WRAP=0.
  - With CE=0 or ACTIVE=0, acc holds its value.
- Retrigger (NOTE_ON while in RUN, DIV or LOAD):
  - NOTE is re-latched and DIV restarts from the new NOTE; a NOTE_ON during DIV abandons the old computation.
  - ACTIVE stays at its prior value, and acc keeps advancing on CE using the old inc until LOAD.
  - If RESET_ON_TRIG=1, acc is cleared on the NOTE_ON edge.
- NOTE_OFF: the next edge gives state=IDLE, ACTIVE=0, inc=0, acc=0. It aborts any pending DIV/LOAD, so BUSY drops.
- Simultaneous events:
  - NOTE_ON and NOTE_OFF in the same cycle: NOTE_ON wins and NOTE_OFF is ignored.
  - CE coinciding with the LOAD edge: the accumulation uses the old inc; the new inc applies from the next CE.
- PHASE is taken directly from the registered acc, adding no extra latency. WRAP is registered.
- NOTE is don't-care except on the NOTE_ON cycle.

Test Plan:
- RST held 3 cycles while NOTE_ON, NOTE_OFF and CE toggle -> PHASE=0, ACTIVE=0, BUSY=0, WRAP=0 throughout and one cycle after release.
- NOTE_ON with NOTE=69, CE idle -> BUSY high for exactly 7 cycles, ACTIVE rises with inc=600. Then 100 CE pulses -> acc=60000, PHASE=117, no WRAP.
- Continue note 69 from acc=0 -> the first WRAP occurs on the 110th CE, leaving acc=464 (66000-65536).
- Boundary notes, each issued from IDLE:
  - NOTE=0 gives inc=11 with BUSY for 2 cycles.
  - NOTE=127 gives inc=17127 with BUSY for 12 cycles.
  - NOTE=60 gives inc=357.
- Retrigger 69 -> 81 mid-run with RESET_ON_TRIG=0 -> acc keeps counting by 600 on CE until LOAD, then by 1201, with no discontinuity. With RESET_ON_TRIG=1 -> acc=0 on the edge after NOTE_ON.
- NOTE_ON and NOTE_OFF asserted in the same cycle -> note starts normally. A NOTE_OFF during DIV -> BUSY drops next cycle, ACTIVE=0, PHASE=0.

Source files
------------

// File: rtl/phase_gen.sv
// phase_gen: per-voice oscillator front end.
// Turns a MIDI note number into a phase increment, using a 12-entry semitone
// table and a sequential divide-by-12, then runs a phase accumulator on CE.
module phase_gen #(
  parameter int ACC_WIDTH     = 16,
  parameter int PHASE_WIDTH   = 7,
  parameter int RESET_ON_TRIG = 0
) (
  input  logic                   CLK,
  input  logic                   RST,
  input  logic                   CE,
  input  logic [6:0]             NOTE,
  input  logic                   NOTE_ON,
  input  logic                   NOTE_OFF,
  output logic [PHASE_WIDTH-1:0] PHASE,
  output logic                   ACTIVE,
  output logic                   BUSY,
  output logic                   WRAP
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_DIV  = 2'd1,
    S_LOAD = 2'd2,
    S_RUN  = 2'd3
  } state_t;

  state_t                 state;
  state_t                 state_nxt;
  logic [6:0]             rem;
  logic [3:0]             oct;
  logic [ACC_WIDTH-1:0]   inc;
  logic [ACC_WIDTH-1:0]   acc;
  logic                   active;
  logic                   wrap;
  logic                   load_en;
  logic                   rem_ge12;
  logic [ACC_WIDTH:0]     sum;

  // Top-octave (octave 10) increments for one semitone each, 16-bit at 48 kHz.
  function automatic logic [15:0] base_lut(input logic [3:0] s);
    logic [15:0] b;
    case (s)
      4'd0:    b = 16'd11431;
      4'd1:    b = 16'd12110;
      4'd2:    b = 16'd12830;
      4'd3:    b = 16'd13593;
      4'd4:    b = 16'd14402;
      4'd5:    b = 16'd15258;
      4'd6:    b = 16'd16165;
      4'd7:    b = 16'd17127;
      4'd8:    b = 16'd18145;
      4'd9:    b = 16'd19224;
      4'd10:   b = 16'd20367;
      4'd11:   b = 16'd21578;
      default: b = 16'd0;
    endcase
    return b;
  endfunction

  // Lower octaves are the top-octave value shifted right (truncating).
  function automatic logic [ACC_WIDTH-1:0] note_inc(input logic [3:0] s,
                                                    input logic [3:0] o);
    logic [15:0] shifted;
    shifted = base_lut(s) >> (4'd10 - o);
    return ACC_WIDTH'(shifted);
  endfunction

  assign rem_ge12 = (rem >= 7'd12);
  assign sum      = {1'b0, acc} + {1'b0, inc};

  // State register.
  always_ff @(posedge CLK) begin
    if (RST) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic: NOTE_ON always restarts the divide, NOTE_OFF aborts.
  always_comb begin
    state_nxt = state;
    if (NOTE_ON) begin
      state_nxt = S_DIV;
    end else if (NOTE_OFF) begin
      state_nxt = S_IDLE;
    end else begin
      case (state)
        S_IDLE:  state_nxt = S_IDLE;
        S_DIV:   state_nxt = rem_ge12 ? S_DIV : S_LOAD;
        S_LOAD:  state_nxt = S_RUN;
        S_RUN:   state_nxt = S_RUN;
        default: state_nxt = S_IDLE;
      endcase
    end
  end

  // Output decode from the current state.
  always_comb begin
    BUSY    = 1'b0;
    load_en = 1'b0;
    case (state)
      S_DIV:   BUSY = 1'b1;
      S_LOAD:  begin BUSY = 1'b1; load_en = 1'b1; end
      default: begin BUSY = 1'b0; load_en = 1'b0; end
    endcase
  end

  // Repeated-subtraction divide by 12: rem ends as semitone, oct as octave.
  always_ff @(posedge CLK) begin
    if (RST) begin
      rem <= '0;
      oct <= '0;
    end else if (NOTE_ON) begin
      rem <= NOTE;
      oct <= '0;
    end else if (state == S_DIV && rem_ge12) begin
      rem <= rem - 7'd12;
      oct <= oct + 4'd1;
    end
  end

  // Increment and ACTIVE flag; a retrigger leaves both untouched until LOAD.
  always_ff @(posedge CLK) begin
    if (RST) begin
      inc    <= '0;
      active <= 1'b0;
    end else if (NOTE_ON) begin
      inc    <= inc;
      active <= active;
    end else if (NOTE_OFF) begin
      inc    <= '0;
      active <= 1'b0;
    end else if (load_en) begin
      inc    <= note_inc(rem[3:0], oct);
      active <= 1'b1;
    end
  end

  // Phase accumulator with registered carry-out pulse.
  always_ff @(posedge CLK) begin
    if (RST) begin
      acc  <= '0;
      wrap <= 1'b0;
    end else if (NOTE_ON && (RESET_ON_TRIG != 0)) begin
      acc  <= '0;
      wrap <= 1'b0;
    end else if (NOTE_OFF && !NOTE_ON) begin
      acc  <= '0;
      wrap <= 1'b0;
    end else if (CE && active) begin
      acc  <= sum[ACC_WIDTH-1:0];
      wrap <= sum[ACC_WIDTH];
    end else begin
      wrap <= 1'b0;
    end
  end

  assign PHASE  = acc[ACC_WIDTH-1 -: PHASE_WIDTH];
  assign ACTIVE = active;
  assign WRAP   = wrap;

endmodule

// File: tb/tb_phase_gen.sv
// tb_phase_gen: directed stimulus, a note-level reference model compared
// every cycle, plus literal expectations for the documented examples.
module tb_phase_gen;

  logic       CLK;
  logic       RST;
  logic       CE;
  logic [6:0] NOTE;
  logic       NOTE_ON;
  logic       NOTE_OFF;
  logic [6:0] PHASE0, PHASE1;
  logic       ACTIVE0, ACTIVE1, BUSY0, BUSY1, WRAP0, WRAP1;

  int errors = 0;
  int checks = 0;

  // Reference model state (index 0: continuous retrigger, 1: reset on trigger)
  int base_tab [12] = '{11431, 12110, 12830, 13593, 14402, 15258,
                        16165, 17127, 18145, 19224, 20367, 21578};
  int m_acc  [2];
  int m_wrap [2];
  int m_inc;
  int m_pend;
  int m_active;
  int m_busy_cnt;

  phase_gen #(.ACC_WIDTH(16), .PHASE_WIDTH(7), .RESET_ON_TRIG(0)) dut0 (
    .CLK(CLK), .RST(RST), .CE(CE), .NOTE(NOTE), .NOTE_ON(NOTE_ON),
    .NOTE_OFF(NOTE_OFF), .PHASE(PHASE0), .ACTIVE(ACTIVE0), .BUSY(BUSY0),
    .WRAP(WRAP0)
  );

  phase_gen #(.ACC_WIDTH(16), .PHASE_WIDTH(7), .RESET_ON_TRIG(1)) dut1 (
    .CLK(CLK), .RST(RST), .CE(CE), .NOTE(NOTE), .NOTE_ON(NOTE_ON),
    .NOTE_OFF(NOTE_OFF), .PHASE(PHASE1), .ACTIVE(ACTIVE1), .BUSY(BUSY1),
    .WRAP(WRAP1)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Note-level model: NOTE_ON arms a countdown of oct+2 busy cycles, after
  // which the table increment becomes the running increment.
  always @(posedge CLK) begin
    int n;
    int s;
    if (RST) begin
      for (int k = 0; k < 2; k++) begin m_acc[k] = 0; m_wrap[k] = 0; end
      m_inc = 0; m_pend = 0; m_active = 0; m_busy_cnt = 0;
    end else begin
      for (int k = 0; k < 2; k++) begin
        if (NOTE_ON && k == 1) begin
          m_acc[k] = 0; m_wrap[k] = 0;
        end else if (NOTE_OFF && !NOTE_ON) begin
          m_acc[k] = 0; m_wrap[k] = 0;
        end else if (CE && m_active != 0) begin
          s = m_acc[k] + m_inc;
          m_wrap[k] = (s >= 65536) ? 1 : 0;
          m_acc[k]  = s % 65536;
        end else begin
          m_wrap[k] = 0;
        end
      end
      if (NOTE_ON) begin
        n = int'(NOTE);
        m_busy_cnt = n / 12 + 2;
        m_pend = base_tab[n % 12] >> (10 - n / 12);
      end else if (NOTE_OFF) begin
        m_busy_cnt = 0; m_inc = 0; m_active = 0;
      end else if (m_busy_cnt > 0) begin
        m_busy_cnt--;
        if (m_busy_cnt == 0) begin
          m_inc = m_pend;
          m_active = 1;
        end
      end
    end
  end

  // Every-cycle comparison of both instances against the model.
  always @(negedge CLK) begin
    chk("phase0",  32'(PHASE0),  32'(m_acc[0] >> 9));
    chk("phase1",  32'(PHASE1),  32'(m_acc[1] >> 9));
    chk("wrap0",   32'(WRAP0),   32'(m_wrap[0]));
    chk("wrap1",   32'(WRAP1),   32'(m_wrap[1]));
    chk("active0", 32'(ACTIVE0), 32'(m_active));
    chk("active1", 32'(ACTIVE1), 32'(m_active));
    chk("busy0",   32'(BUSY0),   32'(m_busy_cnt > 0));
    chk("busy1",   32'(BUSY1),   32'(m_busy_cnt > 0));
  end

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  // Issue a NOTE_ON and count how many cycles BUSY stays high afterwards.
  task automatic start_note(input int n, input logic with_off, output int cnt);
    NOTE = 7'(n);
    NOTE_ON = 1'b1;
    NOTE_OFF = with_off;
    step();
    NOTE_ON = 1'b0;
    NOTE_OFF = 1'b0;
    cnt = 0;
    while (BUSY0 === 1'b1 && cnt < 40) begin
      cnt++;
      step();
    end
  endtask

  task automatic ce_pulse(output logic w);
    CE = 1'b1;
    step();
    CE = 1'b0;
    w = WRAP0;
    step();
  endtask

  task automatic note_off();
    NOTE_OFF = 1'b1;
    step();
    NOTE_OFF = 1'b0;
  endtask

  initial begin
    int   cnt;
    int   wraps;
    int   first;
    logic w;
    int   bn [3] = '{0, 127, 60};
    int   bb [3] = '{2, 12, 7};
    int   bi [3] = '{11, 17127, 357};

    RST = 1'b1; CE = 1'b0; NOTE = 7'd0; NOTE_ON = 1'b0; NOTE_OFF = 1'b0;
    for (int i = 0; i < 3; i++) begin
      NOTE = 7'd69;
      NOTE_ON  = (i % 2 == 0);
      NOTE_OFF = (i % 2 != 0);
      CE = 1'b1;
      step();
      chk("rst_phase", 32'(PHASE0), 0);
      chk("rst_busy",  32'(BUSY0),  0);
    end
    RST = 1'b0; NOTE_ON = 1'b0; NOTE_OFF = 1'b0; CE = 1'b0;
    step();
    chk("post_rst_phase",  32'(PHASE0),  0);
    chk("post_rst_active", 32'(ACTIVE0), 0);
    chk("post_rst_busy",   32'(BUSY0),   0);
    chk("post_rst_wrap",   32'(WRAP0),   0);

    // Note 69: 7 busy cycles, inc 600
    start_note(69, 1'b0, cnt);
    chk("busy_len_69", 32'(cnt), 7);
    chk("active_69",   32'(ACTIVE0), 1);
    chk("model_inc_69", 32'(m_inc), 600);
    wraps = 0;
    for (int i = 0; i < 100; i++) begin
      ce_pulse(w);
      if (w === 1'b1) wraps++;
    end
    chk("phase_100ce", 32'(PHASE0), 117);
    chk("wraps_100ce", 32'(wraps), 0);
    chk("model_acc_100ce", 32'(m_acc[0]), 60000);
    first = -1;
    for (int i = 100; i < 110; i++) begin
      ce_pulse(w);
      if (w === 1'b1 && first < 0) first = i + 1;
    end
    chk("first_wrap_ce", 32'(first), 110);
    chk("model_acc_wrap", 32'(m_acc[0]), 464);
    chk("phase_wrap", 32'(PHASE0), 0);
    note_off();
    chk("off_active", 32'(ACTIVE0), 0);

    // Boundary notes from IDLE
    for (int j = 0; j < 3; j++) begin
      start_note(bn[j], 1'b0, cnt);
      chk("busy_len_bnd", 32'(cnt), 32'(bb[j]));
      chk("model_inc_bnd", 32'(m_inc), 32'(bi[j]));
      for (int i = 0; i < 60; i++) ce_pulse(w);
      note_off();
      chk("bnd_off_phase", 32'(PHASE0), 0);
    end

    // Retrigger 69 -> 81 with CE running through the recomputation
    start_note(69, 1'b0, cnt);
    for (int i = 0; i < 20; i++) ce_pulse(w);
    NOTE = 7'd81;
    NOTE_ON = 1'b1;
    step();
    NOTE_ON = 1'b0;
    chk("retrig_phase0", 32'(PHASE0), 23);
    chk("retrig_phase1", 32'(PHASE1), 0);
    chk("retrig_active", 32'(ACTIVE0), 1);
    CE = 1'b1;
    for (int i = 0; i < 12; i++) step();
    CE = 1'b0;
    chk("retrig_phase0_end", 32'(PHASE0), 42);
    chk("retrig_phase1_end", 32'(PHASE1), 18);
    chk("model_acc_retrig", 32'(m_acc[0]), 21604);
    note_off();

    // NOTE_ON together with NOTE_OFF: the note starts
    start_note(69, 1'b1, cnt);
    chk("busy_len_both", 32'(cnt), 7);
    chk("active_both", 32'(ACTIVE0), 1);
    for (int i = 0; i < 10; i++) ce_pulse(w);
    chk("phase_both", 32'(PHASE0), 11);

    // NOTE_OFF in the middle of a divide
    NOTE = 7'd127;
    NOTE_ON = 1'b1;
    step();
    NOTE_ON = 1'b0;
    step();
    chk("div_busy", 32'(BUSY0), 1);
    NOTE_OFF = 1'b1;
    step();
    NOTE_OFF = 1'b0;
    chk("abort_busy",   32'(BUSY0),   0);
    chk("abort_active", 32'(ACTIVE0), 0);
    chk("abort_phase",  32'(PHASE0),  0);
    for (int i = 0; i < 4; i++) step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
